// File: rtl/uart_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Byte offsets within the 16-byte register window
  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;

  // STATUS bit positions
  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; only pointers and count are reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the pre-pop occupancy, so a push into a full FIFO is
  // dropped even when a pop happens in the same cycle.
  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: every variable in an always_comb gets a default before any branch,
  // otherwise a missed path infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define which
  // entries are valid, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, STATUS/read register and TX FSM.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] mem_addr,
  input  logic        mem_r_enable,
  input  logic        mem_w_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        uart_tx
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  // Bus decode
  logic       hit;
  logic [3:0] reg_off;
  logic       wr_txdata;
  logic       wr_status;
  logic       rd_status;
  logic       unused_bus;

  assign hit       = (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_off   = {mem_addr[3:2], 2'b00};
  assign wr_txdata = mem_w_enable && hit && (reg_off == UART_TXDATA);
  assign wr_status = mem_w_enable && hit && (reg_off == UART_STATUS);
  assign rd_status = hit && (reg_off == UART_STATUS);
  assign unused_bus = ^{mem_addr[1:0], mem_wdata[31:8]};

  // TX FIFO
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (wr_txdata),
    .wdata_i (mem_wdata[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // TX FSM state
  tx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued frames are contiguous
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            bit_d    = '0;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line is registered from the current state, so it trails the FSM by one cycle
  always_comb begin
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Overflow flag: set wins over a clear in the same cycle
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (wr_status && mem_wdata[STAT_OVERFLOW]) overflow_d = 1'b0;
    if (wr_txdata && fifo_full)                overflow_d = 1'b1;
  end

  // STATUS word and read data register
  logic [31:0] status_word;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    status_word                                       = '0;
    status_word[STAT_BUSY]                            = (state_q != IDLE);
    status_word[STAT_FULL]                            = fifo_full;
    status_word[STAT_EMPTY]                           = fifo_empty;
    status_word[STAT_OVERFLOW]                        = overflow_q;
    status_word[STAT_COUNT_LSB +: STAT_COUNT_W]       = STAT_COUNT_W'(fifo_count);
  end

  // Misses load zero so the parent can OR the read data of all slaves
  always_comb begin
    rdata_d = rdata_q;
    if (mem_r_enable) rdata_d = rd_status ? status_word : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign uart_tx   = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio against a timeline model of frames and STATUS.
module tb_uart_tx_mmio;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic        mem_r_enable = 1'b0;
  logic        mem_w_enable = 1'b0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic        uart_tx;

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_addr     (mem_addr),
    .mem_r_enable (mem_r_enable),
    .mem_w_enable (mem_w_enable),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .uart_tx      (uart_tx)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: every accepted byte with the edge it was pushed and the edge it is popped.
  // A byte is popped at the later of (push + 1) and (previous pop + one frame);
  // its frame then occupies the line for the FRAME cycles after (pop + 1).
  int         push_e[$];
  int         pop_e[$];
  logic [7:0] byte_v[$];
  int         last_pop = -1000;
  logic       ovf = 1'b0;
  logic [31:0] exp_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int count_at(input int k);
    int n;
    n = 0;
    foreach (pop_e[i]) if (push_e[i] <= k && pop_e[i] > k) n++;
    return n;
  endfunction

  function automatic logic busy_at(input int k);
    foreach (pop_e[i]) if (pop_e[i] <= k && k < pop_e[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic line_at(input int k);
    int b;
    foreach (pop_e[i]) begin
      if (k >= pop_e[i] + 1 && k <= pop_e[i] + FRAME) begin
        b = (k - pop_e[i] - 1) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return byte_v[i][b-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] status_at(input int k);
    int n;
    n = count_at(k);
    return {16'h0, 8'(n), 4'h0, ovf, (n == 0), (n == DEPTH), busy_at(k)};
  endfunction

  // One clock: drive the bus, advance the model for this edge, then compare.
  task automatic step(input logic we, input logic re, input logic [31:0] addr,
                      input logic [31:0] wd);
    logic       hit;
    logic [1:0] off;
    int         e;
    int         occ;
    mem_w_enable = we;
    mem_r_enable = re;
    mem_addr     = addr;
    mem_wdata    = wd;
    @(posedge clk);
    cyc++;
    e   = cyc;
    hit = (addr[31:4] == BASE[31:4]);
    off = addr[3:2];
    if (!reset_n) begin
      push_e.delete();
      pop_e.delete();
      byte_v.delete();
      last_pop  = -1000;
      ovf       = 1'b0;
      exp_rdata = 32'h0;
    end else begin
      if (re) exp_rdata = (hit && off == 2'd1) ? status_at(e - 1) : 32'h0;
      if (we && hit && off == 2'd0) begin
        occ = 0;
        foreach (pop_e[i]) if (push_e[i] < e && pop_e[i] >= e) occ++;
        if (occ == DEPTH) begin
          ovf = 1'b1;
        end else begin
          last_pop = (e + 1 > last_pop + FRAME) ? e + 1 : last_pop + FRAME;
          push_e.push_back(e);
          pop_e.push_back(last_pop);
          byte_v.push_back(wd[7:0]);
        end
      end else if (we && hit && off == 2'd1 && wd[3]) begin
        ovf = 1'b0;
      end
    end
    #1;
    check("uart_tx", {31'h0, uart_tx}, {31'h0, line_at(e)});
    check("mem_rdata", mem_rdata, exp_rdata);
    mem_w_enable = 1'b0;
    mem_r_enable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    step(1'b1, 1'b0, addr, wd);
  endtask

  task automatic rd(input logic [31:0] addr);
    step(1'b0, 1'b1, addr, 32'h0);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          r;

    // Reset and idle
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(50);
    rd(BASE + 32'h4);
    check("status_after_reset", mem_rdata, 32'h0000_0004);

    // Single frame, polling STATUS throughout
    wr(BASE, 32'h55);
    repeat (45) rd(BASE + 32'h4);
    idle(5);

    // Three back-to-back frames
    wr(BASE, 32'hA1);
    wr(BASE, 32'hB2);
    wr(BASE, 32'hC3);
    idle(3 * FRAME + 10);

    // Overflow: six writes while the first frame is in flight
    for (int i = 0; i < 6; i++) wr(BASE, 32'($urandom_range(0, 255)));
    rd(BASE + 32'h4);
    check("status_overflow", mem_rdata, 32'h0000_040B);
    wr(BASE + 32'h4, 32'h8);
    rd(BASE + 32'h4);
    check("status_ovf_cleared", mem_rdata, 32'h0000_0403);
    idle(5 * FRAME + 10);

    // Read latency, miss and hold behaviour mid-frame
    wr(BASE, 32'h96);
    idle(10);
    rd(BASE + 32'h4);
    check("busy_mid_frame", {31'h0, mem_rdata[0]}, 32'h1);
    rd(32'h2000_0004);
    check("miss_read_zero", mem_rdata, 32'h0);
    rd(BASE + 32'h7);
    step(1'b0, 1'b0, BASE + 32'h4, 32'h0);
    step(1'b0, 1'b0, 32'h2000_0004, 32'h0);
    rd(BASE + 32'h8);
    idle(FRAME);

    // Reset during DATA bit 3, then a clean frame
    wr(BASE, 32'hC6);
    idle(18);
    reset_n = 1'b0;
    idle(1);
    check("line_high_in_reset", {31'h0, uart_tx}, 32'h1);
    reset_n = 1'b1;
    rd(BASE + 32'h4);
    check("status_after_midframe_reset", mem_rdata, 32'h0000_0004);
    wr(BASE, 32'h3C);
    idle(FRAME + 5);

    // Randomized bus traffic
    repeat (2500) begin
      r = $urandom_range(0, 199);
      case ($urandom_range(0, 5))
        0:       a = BASE;
        1:       a = BASE + 32'h4;
        2:       a = BASE + 32'h8;
        3:       a = BASE + 32'hC;
        4:       a = 32'h2000_0004;
        default: a = $urandom;
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      if (r < 30) begin
        wr({BASE[31:4], 2'b00, 2'($urandom_range(0, 3))}, $urandom);
      end else if (r < 36) begin
        wr(a, $urandom);
      end else if (r < 100) begin
        rd(a);
      end else if (r == 199) begin
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
      end else begin
        step(1'b0, 1'b0, a, $urandom);
      end
    end
    idle(DEPTH * FRAME + 2 * FRAME);
    rd(BASE + 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the core's data bus, downstream of the core's load/store port.
- Stores to TXDATA queue bytes in an internal FIFO.
- A baud-rate FSM serialises queued bytes onto `uart_tx` as 8N1 frames.
- Loads from STATUS return busy/full/empty/overflow/count so firmware can poll before writing.

## Interface
Parameters:
- CLKS_PER_BIT, default 868: clk cycles per serial bit (100 MHz / 115200). Minimum 2.
- FIFO_DEPTH, default 8: TX FIFO entries. Power of two, at least 2.
- BASE_ADDR, default 32'h1000_0000: register window base. 16-byte aligned.

Ports:
- clk, input, 1: clock.
- reset_n, input, 1: reset, synchronous, active-low.
- mem_addr, input, 32: byte address from the core.
- mem_r_enable, input, 1: read strobe.
- mem_w_enable, input, 1: write strobe. One cycle per store.
- mem_wdata, input, 32: store data.
- mem_rdata, output, 32: registered read data. Reset 0.
- uart_tx, output, 1: serial line. Idle high, reset 1.

## Operation
- Hit is `mem_addr[31:4] == BASE_ADDR[31:4]`. The register is selected by `mem_addr[3:2]`.
- `mem_addr[1:0]` is ignored. Misses have no effect.
- Offset 0x0, TXDATA:
  - Write with hit pushes `mem_wdata[7:0]` if the FIFO is not full.
  - If the FIFO is full, the byte is dropped and `overflow` is set.
  - Read returns 0.
- Offset 0x4, STATUS (read):
  - bit0 `busy`: FSM not IDLE.
  - bit1 `full`.
  - bit2 `empty`.
  - bit3 `overflow`: sticky.
  - bits[15:8] `count`: FIFO occupancy.
  - Other bits 0.
- Offset 0x4, STATUS (write): `mem_wdata[3]=1` clears `overflow`. All other bits are ignored.
- Offsets 0x8 and 0xC: reads return 0, writes are ignored.
- Reads have no side effects. The core asserts `mem_r_enable` during instruction fetch with a stale address, and this must be harmless.
- Read data register, on each cycle with `mem_r_enable=1`:
  - On a hit, it loads the selected register.
  - On a miss, it loads 0, so the parent can OR-combine slaves.
  - It holds its value when `mem_r_enable=0`.
- TX FSM, `tx_state_t`:
  - IDLE: `uart_tx=1`. If the FIFO is non-empty, pop into the shift register, clear the baud and bit counters, and go to START.
  - START: `uart_tx=0` for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `uart_tx=shift[0]`, LSB first. Shift right every CLKS_PER_BIT cycles. After 8 bits go to STOP.
  - STOP: `uart_tx=1` for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Counter widths:
  - Baud counter: `$clog2(CLKS_PER_BIT)` bits.
  - Bit counter: 3 bits.
  - FIFO pointers: `$clog2(FIFO_DEPTH)` bits, wrapping naturally.
  - count: `$clog2(FIFO_DEPTH)+1` bits.
- `uart_tx` is driven from a flop. There is no combinational path from the bus to the line.

## Timing
- Read latency is 1 cycle: `mem_rdata` is valid the cycle after `mem_r_enable`, which is the core's WB cycle.
- Push at edge t is visible in STATUS and `count` from t+1.
- In IDLE with an empty FIFO, a push at edge t gives a pop at t+1 and `uart_tx` low from t+2.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- Simultaneous push and pop in the same cycle: `full` is evaluated before the pop. A push while full is dropped even if a pop occurs that cycle. Otherwise count is unchanged.
- Simultaneous overflow-set and overflow-clear in the same cycle is impossible (single bus). Set has priority if ever both are asserted.
- Reset (`reset_n=0` at an edge), including mid-frame:
  - State IDLE.
  - FIFO emptied.
  - `overflow=0`.
  - `mem_rdata=0`.
  - `uart_tx=1` from that edge onward.

## Structure
- Package `uart_pkg`:
  - `tx_state_t` (IDLE, START, DATA, STOP).
  - Register offset constants `UART_TXDATA=4'h0`, `UART_STATUS=4'h4`.
  - STATUS bit index constants.
- Sub-module `sync_fifo`:
  - Parameterised width (8) and depth.
  - push/pop/full/empty/count interface.
  - Registered storage, synchronous reset of pointers only.
- Top-level contents: address decode, STATUS/read register, and the TX FSM.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Reset, then idle 50 cycles: `uart_tx=1`, STATUS read = 0x0000_0004.
- Write 0x55 to TXDATA, then sample the line: low 4 cycles starting 2 cycles after the write, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high. Busy clears after 40 cycles.
- Write 0xA1, 0xB2, 0xC3 back-to-back: three contiguous frames (120 cycles), no idle gap between them, bytes decode in order.
- Write 6 bytes while the first frame is in flight: count reaches 4, full=1, overflow=1. Only 5 frames are emitted (1 in shift register + 4 queued). Writing 0x8 to STATUS clears overflow.
- Read STATUS at 0x1000_0004 mid-frame: `mem_rdata` updates exactly 1 cycle later with busy=1. A read at 0x2000_0004 gives `mem_rdata=0`. A read with `mem_r_enable=0` leaves `mem_rdata` unchanged.
- Assert `reset_n=0` during DATA bit 3: `uart_tx=1` from the next edge, count=0. A subsequent write transmits a clean frame.
